// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: single-outstanding imem request, response FIFO, PC pause control
module inst_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        pause_i,
   output logic        pc_pause_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_misalign_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_RESP = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   req_pc_q, req_pc_d;

   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];
   logic [DEPTH-1:0] fifo_mis_q;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;

   logic          space;
   logic          aligned;
   logic          push;
   logic          pop;
   logic [31:0]   push_pc;
   logic [31:0]   push_inst;
   logic          push_mis;

   assign space       = (count_q < CW'(DEPTH));
   assign aligned     = (pc_i[1:0] == 2'b00);
   assign imem_addr_o = pc_i;

   // Space is reserved at issue time, so a response push never overflows.
   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      imem_req_o = 1'b0;
      pc_pause_o = 1'b1;
      push       = 1'b0;
      push_pc    = req_pc_q;
      push_inst  = imem_rdata_i;
      push_mis   = 1'b0;
      case (state_q)
         S_REQ: begin
            if (space && !flush_i) begin
               if (aligned) begin
                  imem_req_o = 1'b1;
                  if (imem_gnt_i) begin
                     req_pc_d   = pc_i;
                     state_d    = S_RESP;
                     pc_pause_o = 1'b0;
                  end
               end else begin
                  push       = 1'b1;
                  push_pc    = pc_i;
                  push_inst  = NOP_INST;
                  push_mis   = 1'b1;
                  pc_pause_o = 1'b0;
               end
            end
         end
         S_RESP: begin
            if (imem_rvalid_i) begin
               state_d = S_REQ;
               push    = !flush_i;
            end else if (flush_i) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
      if (rst) begin
         imem_req_o = 1'b0;
         pc_pause_o = 1'b1;
      end
   end

   assign if_valid_o = (count_q != '0);
   assign pop        = if_valid_o && !pause_i && !flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_REQ;
         req_pc_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= push_pc;
         fifo_inst_q[wr_ptr_q] <= push_inst;
         fifo_mis_q[wr_ptr_q]  <= push_mis;
      end
   end

   // Head fields read as zero while empty so reset presents a clean boundary.
   assign if_pc_o       = if_valid_o ? fifo_pc_q[rd_ptr_q]   : '0;
   assign if_inst_o     = if_valid_o ? fifo_inst_q[rd_ptr_q] : '0;
   assign if_misalign_o = if_valid_o ? fifo_mis_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with queue-based reference model
module tb_inst_fetch;

   localparam int DEPTH = 2;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst, flush_i, pause_i, imem_gnt_i, imem_rvalid_i;
   logic [31:0] pc_i, imem_rdata_i;
   logic        pc_pause_o, imem_req_o, if_valid_o, if_misalign_o;
   logic [31:0] imem_addr_o, if_pc_o, if_inst_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } ent_t;

   ent_t        q[$];
   int          pend;     // 0 none outstanding, 1 keep the response, 2 discard the response
   logic [31:0] ppc;

   inst_fetch #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .pause_i(pause_i),
      .pc_pause_o(pc_pause_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .if_misalign_o(if_misalign_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: compare outputs against the model mid-cycle, then advance the model across the edge.
   task automatic step();
      bit   space, aligned, exp_req, exp_pause;
      ent_t e;
      @(negedge clk);
      space   = (q.size() < DEPTH);
      aligned = (pc_i[1:0] == 2'b00);
      if (rst || pend != 0) begin
         exp_req = 0; exp_pause = 1;
      end else begin
         exp_req   = space && !flush_i && aligned;
         exp_pause = !(space && (!aligned || imem_gnt_i));
      end
      chk("imem_req", {31'd0, imem_req_o}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr_o, pc_i);
      if (rst || !flush_i) chk("pc_pause", {31'd0, pc_pause_o}, {31'd0, exp_pause});
      chk("if_valid", {31'd0, if_valid_o}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("if_pc", if_pc_o, q[0].pc);
         chk("if_inst", if_inst_o, q[0].inst);
         chk("if_misalign", {31'd0, if_misalign_o}, {31'd0, q[0].mis});
      end
      if (rst) begin
         q.delete();
         pend = 0;
      end else begin
         if (q.size() != 0 && !pause_i && !flush_i) void'(q.pop_front());
         if (pend == 0) begin
            if (space && !flush_i) begin
               if (!aligned) begin
                  e.pc = pc_i; e.inst = NOP; e.mis = 1'b1;
                  q.push_back(e);
               end else if (imem_gnt_i) begin
                  pend = 1; ppc = pc_i;
               end
            end
         end else if (pend == 1) begin
            if (imem_rvalid_i) begin
               if (!flush_i) begin
                  e.pc = ppc; e.inst = imem_rdata_i; e.mis = 1'b0;
                  q.push_back(e);
               end
               pend = 0;
            end else if (flush_i) begin
               pend = 2;
            end
         end else if (imem_rvalid_i) begin
            pend = 0;
         end
         if (flush_i) q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
   endtask

   task automatic do_reset();
      idle();
      pause_i = 0; pc_i = '0;
      rst = 1; step(); step();
      rst = 0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d);
      pc_i = a; imem_gnt_i = 1; step();
      imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = d; step();
      imem_rvalid_i = 0;
   endtask

   initial begin
      pend = 0; ppc = '0;
      rst = 1; idle(); pause_i = 0; pc_i = '0;

      // T1: reset state and a single fetch
      step(); step();
      chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
      chk("rst_pc", if_pc_o, 32'd0);
      chk("rst_inst", if_inst_o, 32'd0);
      chk("rst_mis", {31'd0, if_misalign_o}, 32'd0);
      rst = 0; pause_i = 1;
      fetch(32'h0, 32'h00500093);
      chk("t1_valid", {31'd0, if_valid_o}, 32'd1);
      chk("t1_pc", if_pc_o, 32'h0);
      chk("t1_inst", if_inst_o, 32'h00500093);

      // T2: FIFO fills at DEPTH under decode stall, then drains in order
      do_reset();
      pause_i = 1;
      fetch(32'h0, 32'h11110000);
      fetch(32'h4, 32'h22220000);
      pc_i = 32'h8; imem_gnt_i = 1; step(); step();
      chk("t2_full_req", {31'd0, imem_req_o}, 32'd0);
      chk("t2_full_pause", {31'd0, pc_pause_o}, 32'd1);
      chk("t2_head", if_pc_o, 32'h0);
      imem_gnt_i = 0; pause_i = 0; step();
      chk("t2_head2", if_pc_o, 32'h4);
      fetch(32'h8, 32'h33330000);
      step(); step();
      chk("t2_empty", {31'd0, if_valid_o}, 32'd0);

      // T3: flush after grant discards the late response
      do_reset();
      pc_i = 32'h10; imem_gnt_i = 1; step();
      imem_gnt_i = 0; flush_i = 1; pc_i = 32'h100; step();
      flush_i = 0; step();
      imem_rvalid_i = 1; imem_rdata_i = 32'hDEADBEEF; step();
      imem_rvalid_i = 0; step();
      chk("t3_valid", {31'd0, if_valid_o}, 32'd0);
      chk("t3_req", {31'd0, imem_req_o}, 32'd1);
      chk("t3_addr", imem_addr_o, 32'h100);

      // T4: misaligned PC produces a NOP entry without a memory request
      do_reset();
      pause_i = 1; pc_i = 32'h6; step();
      pc_i = 32'h8;
      chk("t4_valid", {31'd0, if_valid_o}, 32'd1);
      chk("t4_pc", if_pc_o, 32'h6);
      chk("t4_inst", if_inst_o, NOP);
      chk("t4_mis", {31'd0, if_misalign_o}, 32'd1);

      // T5: grant withheld, request held stable
      do_reset();
      pc_i = 32'h20;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_req", {31'd0, imem_req_o}, 32'd1);
         chk("t5_addr", imem_addr_o, 32'h20);
         chk("t5_pause", {31'd0, pc_pause_o}, 32'd1);
      end

      // T6: reset mid-transaction, late response ignored
      do_reset();
      pc_i = 32'h40; imem_gnt_i = 1; step();
      imem_gnt_i = 0; rst = 1; step();
      rst = 0; step();
      pc_i = 32'h44; imem_rvalid_i = 1; imem_rdata_i = 32'hCAFEF00D; step();
      imem_rvalid_i = 0; step();
      chk("t6_valid", {31'd0, if_valid_o}, 32'd0);
      chk("t6_req", {31'd0, imem_req_o}, 32'd1);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst           = ($urandom_range(0, 99) == 0);
         flush_i       = ($urandom_range(0, 15) == 0);
         pause_i       = ($urandom_range(0, 2) == 0);
         imem_gnt_i    = $urandom_range(0, 1);
         imem_rvalid_i = (pend != 0) && ($urandom_range(0, 1) == 1);
         imem_rdata_i  = $urandom;
         pc_i          = $urandom & 32'h0000_0FFC;
         if ($urandom_range(0, 7) == 0) pc_i[1:0] = 2'($urandom_range(1, 3));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
